game_sequencer: RTL and testbench

//  Drives the score calculator: paces the game with a one-cycle tick, issues

---
 rtl/game_sequencer_if.sv | 22 ++
 rtl/game_sequencer.sv | 124 ++++++++++++
 tb/tb_game_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control and score-calculator signals of the game sequencer
interface game_if;
    logic       start;
    logic       btn;
    logic       game_clk;
    logic [7:0] pattern;
    logic       write;
    logic       score_clear;
    logic [7:0] round;
    logic       active;
    logic       done;

    modport master (
        output start, btn,
        input  game_clk, pattern, write, score_clear, round, active, done
    );

    modport slave (
        input  start, btn,
        output game_clk, pattern, write, score_clear, round, active, done
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game pacing, pattern scheduling and button-to-write strobes
module game_sequencer #(
    parameter int unsigned TICK_CYCLES = 25_000_000,
    parameter int unsigned GAP_TICKS   = 3,
    parameter int unsigned ROUNDS      = 16,
    parameter int unsigned DRAIN_TICKS = 10,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic  CLOCK50M,
    input  logic  reset,
    game_if.slave bus
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam int GW = $clog2(GAP_TICKS + 2);
    localparam int DW = $clog2(DRAIN_TICKS + 2);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_TICKS);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TICKS);
    localparam logic [7:0]    LAST_ROUND = 8'(ROUNDS - 1);
    localparam logic [7:0]    SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [TW-1:0]   tick_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [DW-1:0]   drain_cnt;
    logic [7:0]      lfsr;
    logic [7:0]      round_q;
    logic [7:0]      pattern_q;
    logic            game_clk_q;
    logic            score_clear_q;
    logic            btn_s1, btn_s2, btn_s3;
    logic            pend;

    logic            counting, start_ok, tick_now, pattern_tick, drain_end;
    logic            btn_rise, write_now;
    logic [7:0]      lfsr_next;

    assign counting     = (state == RUN) || (state == DRAIN);
    assign start_ok     = bus.start && ((state == IDLE) || (state == DONE));
    assign tick_now     = counting && (tick_cnt == TICK_LAST);
    assign pattern_tick = (state == RUN) && tick_now && (gap_cnt == '0);
    // The tick that enters DRAIN is counted as number zero, so DONE follows the DRAIN_TICKS-th later tick.
    assign drain_end    = (state == DRAIN) && game_clk_q && (drain_cnt == DRAIN_LAST);
    assign btn_rise     = btn_s2 && !btn_s3;
    assign write_now    = pend && !game_clk_q;
    assign lfsr_next    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge CLOCK50M or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (pattern_tick && (round_q == LAST_ROUND)) state_next = DRAIN;
            DRAIN:   if (drain_end) state_next = DONE;
            DONE:    if (start_ok) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK50M or posedge reset) begin
        if (reset) begin
            tick_cnt      <= '0;
            gap_cnt       <= '0;
            drain_cnt     <= '0;
            lfsr          <= SEED;
            round_q       <= 8'h00;
            pattern_q     <= 8'h00;
            game_clk_q    <= 1'b0;
            score_clear_q <= 1'b0;
        end else begin
            score_clear_q <= start_ok;
            game_clk_q    <= tick_now;
            pattern_q     <= pattern_tick ? lfsr : 8'h00;
            if (start_ok) begin
                tick_cnt  <= '0;
                gap_cnt   <= '0;
                drain_cnt <= '0;
                lfsr      <= SEED;
                round_q   <= 8'h00;
            end else begin
                if (drain_end)     tick_cnt <= '0;
                else if (counting) tick_cnt <= tick_now ? '0 : tick_cnt + 1'b1;
                if (pattern_tick) begin
                    round_q <= round_q + 8'd1;
                    gap_cnt <= GAP_LOAD;
                    lfsr    <= lfsr_next;
                end else if ((state == RUN) && tick_now) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                if ((state == DRAIN) && game_clk_q && !drain_end) drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    // A pending press waits out a tick cycle; further edges while pending merge into it.
    always_ff @(posedge CLOCK50M or posedge reset) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_s3 <= 1'b0;
            pend   <= 1'b0;
        end else begin
            btn_s1 <= bus.btn;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
            if (start_ok) pend <= 1'b0;
            else          pend <= (pend && !write_now) || (btn_rise && counting && !pend);
        end
    end

    assign bus.game_clk    = game_clk_q;
    assign bus.pattern     = pattern_q;
    assign bus.write       = write_now;
    assign bus.score_clear = score_clear_q;
    assign bus.round       = round_q;
    assign bus.active      = counting;
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer
module tb_game_sequencer;
    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  pattern;
        logic        gclk;
        logic        wr;
        logic        clr;
        logic [7:0]  round;
        logic        act;
        logic        dn;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  exp_q[$];
    logic [7:0] q2[$];
    int   t0, t1, t2;

    game_if bus();
    game_if bus2();

    game_sequencer #(.TICK_CYCLES(4), .GAP_TICKS(1), .ROUNDS(3), .DRAIN_TICKS(2), .LFSR_SEED(8'hA5))
        dut (.CLOCK50M(clk), .reset(reset), .bus(bus));

    game_sequencer #(.TICK_CYCLES(2), .GAP_TICKS(0), .ROUNDS(255), .DRAIN_TICKS(1), .LFSR_SEED(8'h00))
        dut_lfsr (.CLOCK50M(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(int c, logic [7:0] p, logic g, logic w, logic s, logic [7:0] r, logic a, logic d);
        ev_t e;
        e.cyc = c; e.pattern = p; e.gclk = g; e.wr = w; e.clr = s; e.round = r; e.act = a; e.dn = d;
        return e;
    endfunction

    function automatic logic [7:0] lfsr_step(logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [31:0] outs();
        return {11'd0, bus.game_clk, bus.pattern, bus.write, bus.score_clear, bus.round, bus.active, bus.done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h required=%h", name, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        ev_t got, e;
        if (!reset && (bus.game_clk || bus.write || bus.score_clear || bus.pattern != 8'h00)) begin
            got = mk(cyc, bus.pattern, bus.game_clk, bus.write, bus.score_clear, bus.round, bus.active, bus.done);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got === e) n_pass++;
                else $display("FAIL event got=%h required=%h", got, e);
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e2;
        if (!reset && bus2.game_clk && (bus2.round != 8'd255 || bus2.pattern != 8'h00)) begin
            n_checks++;
            if (q2.size() == 0) begin
                $display("FAIL lfsr_extra_pattern got=%h required=none", bus2.pattern);
            end else begin
                e2 = q2.pop_front();
                if (bus2.pattern === e2 && bus2.pattern != 8'h00) n_pass++;
                else $display("FAIL lfsr_pattern got=%h required=%h", bus2.pattern, e2);
            end
        end
    end

    initial begin
        logic [7:0] v;
        reset = 1'b1;
        bus.start = 1'b0; bus.btn = 1'b0;
        bus2.start = 1'b0; bus2.btn = 1'b0;
        wait_cycles(3);
        check("reset_outputs", outs(), 32'd0);
        reset = 1'b0;

        // idle: button presses are dropped
        wait_cycles(4);
        t0 = cyc;
        bus.btn = 1'b1; wait_cycles(1); bus.btn = 1'b0;
        goto(t0 + 3);
        check("idle_btn_no_write", {31'd0, bus.write}, 32'd0);
        goto(t0 + 20);
        check("idle_outputs", outs(), 32'd0);

        // game 1 with button traffic
        wait_cycles(1);
        t0 = cyc;
        exp_q.push_back(mk(t0 + 1,  8'h00, 0, 0, 1, 8'd0, 1, 0));
        exp_q.push_back(mk(t0 + 5,  8'hA5, 1, 0, 0, 8'd1, 1, 0));
        exp_q.push_back(mk(t0 + 9,  8'h00, 1, 0, 0, 8'd1, 1, 0));
        exp_q.push_back(mk(t0 + 13, 8'h4A, 1, 0, 0, 8'd2, 1, 0));
        exp_q.push_back(mk(t0 + 14, 8'h00, 0, 1, 0, 8'd2, 1, 0));
        exp_q.push_back(mk(t0 + 17, 8'h00, 1, 0, 0, 8'd2, 1, 0));
        exp_q.push_back(mk(t0 + 19, 8'h00, 0, 1, 0, 8'd2, 1, 0));
        exp_q.push_back(mk(t0 + 21, 8'h95, 1, 0, 0, 8'd3, 1, 0));
        exp_q.push_back(mk(t0 + 25, 8'h00, 1, 0, 0, 8'd3, 1, 0));
        exp_q.push_back(mk(t0 + 26, 8'h00, 0, 1, 0, 8'd3, 1, 0));
        exp_q.push_back(mk(t0 + 29, 8'h00, 1, 0, 0, 8'd3, 1, 0));
        bus.start = 1'b1; wait_cycles(1); bus.start = 1'b0;
        goto(t0 + 10); bus.btn = 1'b1;
        goto(t0 + 11); bus.btn = 1'b0;
        goto(t0 + 12); bus.btn = 1'b1;
        goto(t0 + 13); bus.btn = 1'b0;
        goto(t0 + 16); bus.btn = 1'b1;
        goto(t0 + 17); bus.btn = 1'b0;
        goto(t0 + 23); bus.btn = 1'b1;
        goto(t0 + 24); bus.btn = 1'b0;
        goto(t0 + 30);
        check("done_after_drain", {22'd0, bus.round, bus.active, bus.done}, {22'd0, 8'd3, 1'b0, 1'b1});
        goto(t0 + 32); bus.btn = 1'b1;
        goto(t0 + 33); bus.btn = 1'b0;
        goto(t0 + 40);
        check("done_hold", {22'd0, bus.round, bus.active, bus.done}, {22'd0, 8'd3, 1'b0, 1'b1});

        // game 2 from DONE, start ignored in RUN, reset mid-run
        goto(t0 + 45);
        t1 = cyc;
        exp_q.push_back(mk(t1 + 1, 8'h00, 0, 0, 1, 8'd0, 1, 0));
        exp_q.push_back(mk(t1 + 5, 8'hA5, 1, 0, 0, 8'd1, 1, 0));
        exp_q.push_back(mk(t1 + 9, 8'h00, 1, 0, 0, 8'd1, 1, 0));
        bus.start = 1'b1; wait_cycles(1); bus.start = 1'b0;
        goto(t1 + 7); bus.start = 1'b1;
        goto(t1 + 8); bus.start = 1'b0;
        goto(t1 + 10);
        check("run_before_reset", {22'd0, bus.round, bus.active, bus.done}, {22'd0, 8'd1, 1'b1, 1'b0});
        reset = 1'b1;
        #2;
        check("mid_reset_outputs", outs(), 32'd0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(10);
        check("idle_after_reset", outs(), 32'd0);

        // game 3 from IDLE after reset
        wait_cycles(1);
        t2 = cyc;
        exp_q.push_back(mk(t2 + 1, 8'h00, 0, 0, 1, 8'd0, 1, 0));
        exp_q.push_back(mk(t2 + 5, 8'hA5, 1, 0, 0, 8'd1, 1, 0));
        bus.start = 1'b1; wait_cycles(1); bus.start = 1'b0;
        goto(t2 + 6);
        check("restart_round", {22'd0, bus.round, bus.active, bus.done}, {22'd0, 8'd1, 1'b1, 1'b0});
        goto(t2 + 7);
        reset = 1'b1; wait_cycles(1); reset = 1'b0;
        wait_cycles(2);

        // zero seed: 255 patterns starting at 8'h01
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            q2.push_back(v);
            v = lfsr_step(v);
        end
        bus2.start = 1'b1; wait_cycles(1); bus2.start = 1'b0;
        for (int i = 0; i < 2000 && !bus2.done; i++) wait_cycles(1);
        check("lfsr_game_done", {31'd0, bus2.done}, 32'd1);
        check("lfsr_round_sat", {24'd0, bus2.round}, 32'd255);
        check("lfsr_queue_empty", q2.size(), 32'd0);
        wait_cycles(3);
        check("event_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
